// File: rtl/dm_arb_pkg.sv
// Shared encodings and default configuration for the data-memory port arbiter.
package dm_arb_pkg;

    typedef enum logic {
        StArb  = 1'b0,
        StCool = 1'b1
    } arb_state_e;

    localparam int unsigned STARVE_MAX_DEF = 8;
    localparam int unsigned CNT_W_DEF      = 4;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Core, external-requester and memory-side signals of the data-memory port arbiter.
interface dm_port_arbiter_if #(
    parameter int unsigned DMA_SIZE = 16,
    parameter int unsigned DMD_SIZE = 16
);
    logic                ps_dm_cslt;
    logic                ps_dm_wrb;
    logic [DMA_SIZE-1:0] dg_dm_add;
    logic [DMD_SIZE-1:0] bc_dt;
    logic                core_stall;
    logic                ext_req;
    logic                ext_wrb;
    logic [DMA_SIZE-1:0] ext_add;
    logic [DMD_SIZE-1:0] ext_wdt;
    logic                ext_gnt;
    logic                ext_rvalid;
    logic [DMD_SIZE-1:0] ext_rdt;
    logic                arb_dm_cslt;
    logic                arb_dm_wrb;
    logic [DMA_SIZE-1:0] arb_dm_add;
    logic [DMD_SIZE-1:0] arb_dm_wdt;
    logic [DMD_SIZE-1:0] dm_arb_rdt;

    modport slave (
        input  ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt,
        input  ext_req, ext_wrb, ext_add, ext_wdt,
        input  dm_arb_rdt,
        output core_stall, ext_gnt, ext_rvalid, ext_rdt,
        output arb_dm_cslt, arb_dm_wrb, arb_dm_add, arb_dm_wdt
    );

    modport master (
        output ps_dm_cslt, ps_dm_wrb, dg_dm_add, bc_dt,
        output ext_req, ext_wrb, ext_add, ext_wdt,
        output dm_arb_rdt,
        input  core_stall, ext_gnt, ext_rvalid, ext_rdt,
        input  arb_dm_cslt, arb_dm_wrb, arb_dm_add, arb_dm_wdt
    );

endinterface

// File: rtl/dm_arb_starve_cnt.sv
// Saturating count of denied external-request cycles; o_hit forces the next external grant.
module dm_arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam logic [CNT_W-1:0] MaxVal = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MaxVal)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == MaxVal);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the data-memory port between the core (priority) and one external requester.
// Optional starvation guard enabled by defining DM_ARB_STARVE_GUARD_EN.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned DMA_SIZE   = 16,
    parameter int unsigned DMD_SIZE   = 16,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    dm_port_arbiter_if.slave   io_bus
);

    localparam int unsigned unused_width = DMA_SIZE;

    arb_state_e          r_state;
    logic                r_rd_pend;
    logic                r_ext_rvalid;
    logic [DMD_SIZE-1:0] r_ext_rdt;
    logic                w_starve_hit;
    logic                w_ext_gnt;

    // Gated by reset so the core keeps the port while reset is held.
    assign w_ext_gnt = reset & (r_state == StArb) & io_bus.ext_req
                     & (~io_bus.ps_dm_cslt | w_starve_hit);

`ifdef DM_ARB_STARVE_GUARD_EN
    logic w_starve_inc;
    logic w_starve_clr;

    assign w_starve_inc = (r_state == StArb) & io_bus.ext_req & ~w_ext_gnt;
    assign w_starve_clr = w_ext_gnt | ~io_bus.ext_req;

    dm_arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX),
        .CNT_W     (CNT_W)
    ) u_starve_cnt (
        .clk  (clk),
        .reset(reset),
        .i_inc(w_starve_inc),
        .i_clr(w_starve_clr),
        .o_hit(w_starve_hit)
    );

    assign io_bus.core_stall = io_bus.ps_dm_cslt & w_ext_gnt;
`else
    localparam int unsigned unused_cfg = STARVE_MAX + CNT_W;

    assign w_starve_hit      = 1'b0;
    assign io_bus.core_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StArb;
            r_rd_pend    <= 1'b0;
            r_ext_rvalid <= 1'b0;
            r_ext_rdt    <= '0;
        end else begin
            unique case (r_state)
                StArb:   if (w_ext_gnt) r_state <= StCool;
                StCool:  r_state <= StArb;
                default: r_state <= StArb;
            endcase
            // Memory returns read data one cycle after the access; register it for the requester.
            r_rd_pend    <= w_ext_gnt & ~io_bus.ext_wrb;
            r_ext_rvalid <= r_rd_pend;
            if (r_rd_pend) begin
                r_ext_rdt <= io_bus.dm_arb_rdt;
            end
        end
    end

    assign io_bus.ext_gnt     = w_ext_gnt;
    assign io_bus.ext_rvalid  = r_ext_rvalid;
    assign io_bus.ext_rdt     = r_ext_rdt;
    assign io_bus.arb_dm_cslt = w_ext_gnt | io_bus.ps_dm_cslt;
    assign io_bus.arb_dm_wrb  = w_ext_gnt ? io_bus.ext_wrb : io_bus.ps_dm_wrb;
    assign io_bus.arb_dm_add  = w_ext_gnt ? io_bus.ext_add : io_bus.dg_dm_add;
    assign io_bus.arb_dm_wdt  = w_ext_gnt ? io_bus.ext_wdt : io_bus.bc_dt;

endmodule
